// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared widths and burst FSM encoding for the pulse divider blocks
package divider_pkg;

  localparam int CNT_W = 32;
  localparam int TIM_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } burst_state_t;

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter timing one HIGH or LOW phase
module phase_timer #(
  parameter int TIM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [TIM_W-1:0] load_val,
  output logic             zero
);

  logic [TIM_W-1:0] count;

  // Saturates at zero; the owner reloads it on every phase entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (enable) begin
      if (load) begin
        count <= load_val;
      end else if (count != '0) begin
        count <= count - TIM_W'(1);
      end
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pulse_burst_gen.sv
// rtl/pulse_burst_gen.sv - emits burst_count pulses of high_cycles/low_cycles, then latches done
module pulse_burst_gen
  import divider_pkg::*;
#(
  parameter int CNT_W = divider_pkg::CNT_W,
  parameter int TIM_W = divider_pkg::TIM_W
) (
  input  logic             pulse_clock,
  input  logic             burst_reset,
  input  logic             burst_enable,
  input  logic             burst_start,
  input  logic [CNT_W-1:0] burst_count,
  input  logic [TIM_W-1:0] high_cycles,
  input  logic [TIM_W-1:0] low_cycles,
  output logic             pulse_out,
  output logic             burst_busy,
  output logic             burst_done,
  output logic [CNT_W-1:0] pulses_sent
);

  burst_state_t     state, state_nxt;
  logic [CNT_W-1:0] cfg_count;
  logic [TIM_W-1:0] cfg_high_ld;
  logic [TIM_W-1:0] cfg_low_ld;
  logic             start_ok;
  logic             tmr_load;
  logic [TIM_W-1:0] tmr_val;
  logic             tmr_zero;
  logic             sent_clr;
  logic             sent_inc;

  // Phase lengths are stored as timer reload values; a zero length runs one clock.
  function automatic logic [TIM_W-1:0] phase_reload(input logic [TIM_W-1:0] len);
    return (len == '0) ? '0 : len - TIM_W'(1);
  endfunction

  phase_timer #(
    .TIM_W (TIM_W)
  ) u_phase_timer (
    .clk      (pulse_clock),
    .rst      (burst_reset),
    .enable   (burst_enable),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = cfg_high_ld;
    sent_clr  = 1'b0;
    sent_inc  = 1'b0;
    start_ok  = burst_start && ((state == ST_IDLE) || (state == ST_DONE));

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          sent_clr = 1'b1;
          if (burst_count == '0) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_HIGH;
            tmr_load  = 1'b1;
            tmr_val   = phase_reload(high_cycles);
            sent_inc  = 1'b1;
          end
        end
      end
      ST_HIGH: begin
        if (tmr_zero) begin
          state_nxt = ST_LOW;
          tmr_load  = 1'b1;
          tmr_val   = cfg_low_ld;
        end
      end
      ST_LOW: begin
        if (tmr_zero) begin
          if (pulses_sent < cfg_count) begin
            state_nxt = ST_HIGH;
            tmr_load  = 1'b1;
            tmr_val   = cfg_high_ld;
            sent_inc  = 1'b1;
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Dropping burst_enable freezes the whole block, including the start qualifier.
  always_ff @(posedge pulse_clock or posedge burst_reset) begin
    if (burst_reset) begin
      state <= ST_IDLE;
    end else if (burst_enable) begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge pulse_clock or posedge burst_reset) begin
    if (burst_reset) begin
      cfg_count   <= '0;
      cfg_high_ld <= '0;
      cfg_low_ld  <= '0;
      pulses_sent <= '0;
      pulse_out   <= 1'b0;
      burst_busy  <= 1'b0;
      burst_done  <= 1'b0;
    end else if (burst_enable) begin
      pulse_out  <= (state_nxt == ST_HIGH);
      burst_busy <= (state_nxt == ST_HIGH) || (state_nxt == ST_LOW);
      burst_done <= (state_nxt == ST_DONE);
      if (start_ok) begin
        cfg_count   <= burst_count;
        cfg_high_ld <= phase_reload(high_cycles);
        cfg_low_ld  <= phase_reload(low_cycles);
      end
      if (sent_clr) begin
        pulses_sent <= sent_inc ? CNT_W'(1) : '0;
      end else if (sent_inc) begin
        pulses_sent <= pulses_sent + CNT_W'(1);
      end
    end
  end

endmodule
